multi_axis_stepper: RTL

Coordinated multi-axis stepper-motor pulse generator for the drawing robot. It succeeds the single-channel `stepper_controller` and sits between the processor's memory-mapped motor command registers and the step/dir driver pins. One command moves all axes together: a Bresenham DDA spreads each axis's steps evenly over the major-axis step count, so the pen traces straight lines. An optional speed ramp can be compiled in.

---
 rtl/stepper_pkg.sv | 18 +
 rtl/step_pulse_gen.sv | 36 +++
 rtl/multi_axis_stepper.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the multi-axis stepper pulse generator.
// The optional speed ramp is selected by the STEPPER_RAMP_EN macro in the top.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The tick interval must leave a full low phase after every step pulse.
  localparam int unsigned MIN_PERIOD_FACTOR = 2;

  function automatic logic [31:0] max_of(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Per-axis step pulse stretcher: a one-clock trigger becomes a step pulse
// exactly PULSE_CYCLES clocks wide.
module step_pulse_gen #(
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic trigger,
  output logic step,
  output logic active,
  output logic last
);

  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step  <= 1'b0;
      cnt_q <= '0;
    end else if (trigger) begin
      step  <= 1'b1;
      cnt_q <= CW'(PULSE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      step  <= 1'b0;
    end
  end

  assign active = step;
  // High during the final high clock; the pulse drops on the next edge.
  assign last   = step && (cnt_q == '0);

endmodule

// File: rtl/multi_axis_stepper.sv
// Coordinated multi-axis stepper pulse generator using a Bresenham DDA.
// Define STEPPER_RAMP_EN to add a linear start-up ramp (half speed to full speed).
module multi_axis_stepper
  import stepper_pkg::*;
#(
  parameter int unsigned NUM_AXES     = 2,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned PERIOD_W     = 32,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned RAMP_SHIFT   = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [NUM_AXES*STEP_W-1:0]   cmd_steps,
  input  logic [NUM_AXES-1:0]          cmd_dir,
  input  logic [PERIOD_W-1:0]          cmd_period,
  input  logic                         abort,
  output logic [NUM_AXES-1:0]          step,
  output logic [NUM_AXES-1:0]          dir,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output state_t                       state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly while the FSM is IDLE, and the command fields are
  // only sampled on that edge.

  localparam int unsigned MIN_PERIOD = MIN_PERIOD_FACTOR * PULSE_CYCLES;
  // One spare bit so eff + ramp (at most 2*eff) cannot wrap.
  localparam int unsigned IW = PERIOD_W + 1;

  if (RAMP_SHIFT >= PERIOD_W) begin : g_bad_ramp_shift
    $error("RAMP_SHIFT must be smaller than PERIOD_W");
  end

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    steps_q [NUM_AXES];
  logic [STEP_W:0]      err_q   [NUM_AXES];
  logic [STEP_W:0]      sum     [NUM_AXES];
  logic [STEP_W-1:0]    major_q, major_c, tick_cnt_q;
  logic [IW-1:0]        eff_q, eff_c, cnt_q, interval;
  logic [NUM_AXES-1:0]  fire_d, fire_q, active, last;
  logic                 accept, tick, last_tick, drain_done, abort_seen_q;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  always_comb begin
    major_c = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      major_c = STEP_W'(max_of(32'(major_c), 32'(cmd_steps[i*STEP_W +: STEP_W])));
    end
  end

  assign eff_c = ({1'b0, cmd_period} < IW'(MIN_PERIOD)) ? IW'(MIN_PERIOD) : {1'b0, cmd_period};

`ifdef STEPPER_RAMP_EN
  logic [IW-1:0] ramp_q, ramp_dec;

  assign ramp_dec = ((eff_q >> RAMP_SHIFT) == '0) ? IW'(1) : (eff_q >> RAMP_SHIFT);
  assign interval = eff_q + ramp_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q <= '0;
    end else if (accept) begin
      ramp_q <= eff_c;
    end else if (state_q == ST_RUN && abort) begin
      ramp_q <= '0;
    end else if (tick) begin
      ramp_q <= (ramp_q > ramp_dec) ? (ramp_q - ramp_dec) : '0;
    end
  end
`else
  assign interval = eff_q;
`endif

  // An abort on the same clock as a tick wins: the tick never happens.
  assign tick      = (state_q == ST_RUN) && !abort && (cnt_q == interval - IW'(1));
  assign last_tick = tick && (tick_cnt_q == major_q - STEP_W'(1));

  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      sum[i]    = err_q[i] + {1'b0, steps_q[i]};
      fire_d[i] = tick && (sum[i] >= {1'b0, major_q});
    end
  end

  // Every pulse either is idle or drops on the coming edge, and none is queued.
  assign drain_done = (fire_q == '0) && ((active & ~last) == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && major_c != '0) state_d = ST_RUN;
      ST_RUN:   if (abort || last_tick)      state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)              state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir          <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      fire_q       <= '0;
      major_q      <= '0;
      eff_q        <= '0;
      cnt_q        <= '0;
      tick_cnt_q   <= '0;
      abort_seen_q <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        steps_q[i] <= '0;
        err_q[i]   <= '0;
      end
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      fire_q  <= fire_d;

      if (accept) begin
        dir          <= cmd_dir;
        major_q      <= major_c;
        eff_q        <= eff_c;
        cnt_q        <= '0;
        tick_cnt_q   <= '0;
        abort_seen_q <= 1'b0;
        for (int i = 0; i < NUM_AXES; i++) begin
          steps_q[i] <= cmd_steps[i*STEP_W +: STEP_W];
          err_q[i]   <= {1'b0, major_c >> 1};
        end
        if (major_c == '0) done <= 1'b1;
      end

      if (state_q == ST_RUN) begin
        if (abort) abort_seen_q <= 1'b1;
        if (tick) begin
          cnt_q      <= '0;
          tick_cnt_q <= tick_cnt_q + STEP_W'(1);
          for (int i = 0; i < NUM_AXES; i++) begin
            err_q[i] <= fire_d[i] ? (sum[i] - {1'b0, major_q}) : sum[i];
          end
        end else begin
          cnt_q <= cnt_q + IW'(1);
        end
      end

      if (state_q == ST_DRAIN && drain_done) begin
        done    <= 1'b1;
        aborted <= abort_seen_q;
      end
    end
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    step_pulse_gen #(
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse (
      .clock   (clock),
      .reset_n (reset_n),
      .trigger (fire_q[a]),
      .step    (step[a]),
      .active  (active[a]),
      .last    (last[a])
    );
  end

endmodule
